hm_sha256_core: RTL and testbench
=================================

HM_SHA256_CORE -- requirements
Module: hm_sha256_core

Interface
REQ-001 SHALL have parameter UNROLL, default 1, giving SHA-256 rounds per clock; legal values are 1, 2 and 4, and any other value fails elaboration.
REQ-002 SHALL have parameter HOLD_DIGEST, default 1; when set to 1, digest holds its value between blocks; when set to 0, digest reads zero except in the cycle done is high.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port n_rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1 bit: request to compress block; sampled only in IDLE.
REQ-006 SHALL have port init, input, 1 bit, sampled with start: 1 seeds from the SHA-256 IV; 0 chains from the held digest.
REQ-007 SHALL have port abort, input, 1 bit: cancels the block in flight.
REQ-008 SHALL have port block, input, 512 bits: message block; word W0 = bits [511:480] and W15 = bits [31:0], big-endian.
REQ-009 SHALL have port ready, output, 1 bit: high exactly when state is IDLE.
REQ-010 SHALL have port busy, output, 1 bit: high in ROUND and FINAL.
REQ-011 SHALL have port done, output, 1 bit: single-cycle pulse marking that digest is valid.
REQ-012 SHALL have port digest, output, 256 bits: H0 = bits [255:224] through H7 = bits [31:0].

Function
REQ-013 SHALL implement the FIPS 180-4 SHA-256 compression of one 512-bit block per start; all additions are modulo 2^32.
REQ-014 SHALL have FSM states IDLE, ROUND and FINAL.
- IDLE -> ROUND on start=1 and abort=0.
- ROUND -> FINAL after 64/UNROLL round cycles.
- FINAL -> IDLE unconditionally.
REQ-015 On the edge that accepts start, the block SHALL:
- capture block into a 16-word schedule window;
- load a..h from the IV (init=1) or the held digest (init=0);
- latch the chaining value used;
- clear the round counter.
REQ-016 SHALL compute the message schedule on the fly in the 16-word sliding window, producing W[t] for t>=16 as sigma1(W[t-2]) + W[t-7] + sigma0(W[t-15]) + W[t-16]; a full 64-word array SHALL NOT be stored.
REQ-017 Each ROUND cycle SHALL apply UNROLL chained rounds and advance the round counter and the window by UNROLL.
REQ-018 On the FINAL edge, the block SHALL:
- add a..h to the latched chaining value;
- register the sum into digest;
- assert done for exactly that following cycle.
REQ-019 Latency SHALL be 64/UNROLL+1 rising edges from the start-accepting edge to done high: 65, 33 and 17 for UNROLL = 1, 2 and 4.
REQ-020 start while busy SHALL be ignored, with no queuing.
REQ-021 start may be asserted in the same cycle done is high, giving back-to-back blocks with one IDLE cycle between them.
REQ-022 abort=1 in ROUND or FINAL SHALL return the FSM to IDLE on the next edge with no done pulse and digest unchanged.
REQ-023 abort=1 together with start=1 in IDLE SHALL leave the block in IDLE (abort wins).
REQ-024 block and init SHALL be don't-care except on the accepting edge.
REQ-025 init=0 after reset SHALL chain from digest = 0, which is legal and defined.

Reset
REQ-026 n_rst low SHALL immediately force:
- state IDLE, ready=1, busy=0, done=0;
- digest=0;
- round counter=0;
- a..h, window and chaining latch = 0.
REQ-027 Reset mid-block SHALL discard the block; the first edge after release SHALL behave as IDLE.

Structure
REQ-028 Shared package hm_sha256_pkg SHALL hold:
- the 64-entry K constant table;
- the 256-bit IV;
- the FSM state enum;
- the functions for rotr, Sigma0/1, sigma0/1, Ch and Maj.
REQ-029 Sub-module hm_sha256_round SHALL be one purely combinational round (a..h, K[t], W[t] in; a..h out), instantiated UNROLL times in a generate chain.
REQ-030 The K lookup SHALL be indexed by the round counter, with no per-index comparison loops.

Verification
REQ-031 The bench SHALL cover each of the following scenarios:
- "abc" padded single block, init=1 -> digest ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad, done after 65 edges (UNROLL=1).
- Empty-message padded block (80000000 then zeros), init=1 -> digest e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
- 56-char "abcdbcdecdefdefg...nopq" as two blocks, init=1 then init=0 back-to-back -> digest 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
- UNROLL=2 and UNROLL=4 rerun of "abc" -> identical digest, done at edges 33 and 17.
- abort at round 20 -> no done, digest unchanged; a new "abc" start then completes correctly.
- start pulsed mid-block and n_rst dropped at round 40 -> start ignored; after reset, outputs equal reset values and ready=1.

Source files
------------

// File: rtl/hm_sha256_pkg.sv
// SHA-256 constants, FSM state type and the bitwise helper functions shared by
// the core and its round sub-module.
package hm_sha256_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_FINAL = 2'd2
  } sha_state_e;

  // Element 0 sits in the most significant bits: a / H0 / W0 first.
  typedef logic [0:7][31:0]  sha_vars_t;
  typedef logic [0:15][31:0] sha_window_t;

  localparam sha_vars_t SHA_IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [0:63][31:0] SHA_K = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input logic [4:0] n);
    logic [63:0] t;
    t = {x, x} >> n;
    return t[31:0];
  endfunction

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return rotr(x, 5'd2) ^ rotr(x, 5'd13) ^ rotr(x, 5'd22);
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return rotr(x, 5'd6) ^ rotr(x, 5'd11) ^ rotr(x, 5'd25);
  endfunction

  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return rotr(x, 5'd7) ^ rotr(x, 5'd18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return rotr(x, 5'd17) ^ rotr(x, 5'd19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f,
                                     input logic [31:0] g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b,
                                      input logic [31:0] c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

endpackage

// File: rtl/hm_sha256_round.sv
// One purely combinational SHA-256 round: working variables a..h, K[t] and
// W[t] in, updated a..h out.
module hm_sha256_round
  import hm_sha256_pkg::*;
(
  input  sha_vars_t   i_vars,
  input  logic [31:0] i_k,
  input  logic [31:0] i_w,
  output sha_vars_t   o_vars
);

  logic [31:0] w_t1;
  logic [31:0] w_t2;

  assign w_t1 = i_vars[7] + big_sigma1(i_vars[4]) + ch(i_vars[4], i_vars[5], i_vars[6])
              + i_k + i_w;
  assign w_t2 = big_sigma0(i_vars[0]) + maj(i_vars[0], i_vars[1], i_vars[2]);

  assign o_vars = {w_t1 + w_t2, i_vars[0], i_vars[1], i_vars[2],
                   i_vars[3] + w_t1, i_vars[4], i_vars[5], i_vars[6]};

endmodule

// File: rtl/hm_sha256_core.sv
// SHA-256 block compression core, UNROLL rounds per clock, with the message
// schedule generated on the fly in a 16-word sliding window.
//   state | meaning
//   IDLE  | waiting for start; ready high
//   ROUND | UNROLL rounds per cycle, 64/UNROLL cycles
//   FINAL | feed-forward add into digest, pulse done
module hm_sha256_core
  import hm_sha256_pkg::*;
#(
  parameter int UNROLL      = 1,
  parameter int HOLD_DIGEST = 1
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         start,
  input  logic         init,
  input  logic         abort,
  input  logic [511:0] block,
  output logic         ready,
  output logic         busy,
  output logic         done,
  output logic [255:0] digest
);

  if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4)) begin : g_bad_unroll
    $error("hm_sha256_core: UNROLL must be 1, 2 or 4");
  end

  localparam logic [5:0] STEP       = 6'(UNROLL);
  localparam logic [5:0] LAST_ROUND = 6'(64 - UNROLL);

  sha_state_e  r_state;
  sha_state_e  w_state_nxt;
  logic [5:0]  r_round;
  sha_vars_t   r_vars;
  sha_vars_t   r_chain;
  sha_vars_t   r_digest;
  sha_window_t r_win;
  logic        r_done;

  sha_vars_t   w_seed;
  sha_vars_t   w_sum;
  sha_vars_t   w_vars_nxt;
  logic        w_accept;
  logic [31:0] w_ext [16+UNROLL];

  assign w_accept = (r_state == ST_IDLE) && start && !abort;
  assign w_seed   = init ? SHA_IV : r_digest;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:  if (start && !abort) w_state_nxt = ST_ROUND;
      ST_ROUND: begin
        if (abort)                      w_state_nxt = ST_IDLE;
        else if (r_round == LAST_ROUND) w_state_nxt = ST_FINAL;
      end
      ST_FINAL: w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Window extended by UNROLL words; words 16.. depend on earlier new words.
  always_comb begin
    for (int i = 0; i < 16 + UNROLL; i++) w_ext[i] = '0;
    for (int i = 0; i < 16; i++) w_ext[i] = r_win[i];
    for (int i = 16; i < 16 + UNROLL; i++) begin
      w_ext[i] = small_sigma1(w_ext[i-2]) + w_ext[i-7]
               + small_sigma0(w_ext[i-15]) + w_ext[i-16];
    end
  end

  for (genvar j = 0; j < UNROLL; j++) begin : g_round
    sha_vars_t  w_in;
    sha_vars_t  w_out;
    logic [5:0] w_kidx;
    if (j == 0) begin : g_head
      assign w_in = r_vars;
    end else begin : g_link
      assign w_in = g_round[j-1].w_out;
    end
    assign w_kidx = r_round + 6'(j);
    hm_sha256_round u_round (
      .i_vars (w_in),
      .i_k    (SHA_K[w_kidx]),
      .i_w    (w_ext[j]),
      .o_vars (w_out)
    );
  end

  assign w_vars_nxt = g_round[UNROLL-1].w_out;

  always_comb begin
    w_sum = '0;
    for (int i = 0; i < 8; i++) w_sum[i] = r_chain[i] + r_vars[i];
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_round  <= '0;
      r_vars   <= '0;
      r_chain  <= '0;
      r_digest <= '0;
      r_win    <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_win   <= block;
            r_vars  <= w_seed;
            r_chain <= w_seed;
            r_round <= '0;
          end
        end
        ST_ROUND: begin
          if (!abort) begin
            r_vars  <= w_vars_nxt;
            r_round <= r_round + STEP;
            for (int i = 0; i < 16; i++) r_win[i] <= w_ext[i+UNROLL];
          end
        end
        ST_FINAL: begin
          if (!abort) begin
            r_digest <= w_sum;
            r_done   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign ready = (r_state == ST_IDLE);
  assign busy  = (r_state == ST_ROUND) || (r_state == ST_FINAL);
  assign done  = r_done;

  if (HOLD_DIGEST != 0) begin : g_hold
    assign digest = r_digest;
  end else begin : g_pulse
    assign digest = r_done ? r_digest : '0;
  end

endmodule

// File: tb/tb_hm_sha256_core.sv
// Directed bench: three cores (UNROLL 1/2/4, the UNROLL=2 one without digest
// hold) driven in parallel with known-answer blocks and corner sequences.
module tb_hm_sha256_core;

  localparam logic [511:0] BLK_ABC   = {32'h61626380, {14{32'h0}}, 32'h00000018};
  localparam logic [511:0] BLK_EMPTY = {32'h80000000, {15{32'h0}}};
  localparam logic [511:0] BLK_2A    = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] BLK_2B    = {{15{32'h0}}, 32'h000001c0};

  localparam logic [255:0] DIG_ABC   =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] DIG_EMPTY =
    256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] DIG_2BLK  =
    256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  typedef struct {
    string          name;
    logic [511:0]   blk;
    logic           ini;
    logic [255:0]   exp;
  } vec_t;

  logic         clk;
  logic         n_rst;
  logic         start;
  logic         init;
  logic         abort;
  logic [511:0] block;
  logic         ready1, busy1, done1;
  logic         ready2, busy2, done2;
  logic         ready4, busy4, done4;
  logic [255:0] digest1, digest2, digest4;

  int           n_vec = 0;
  int           n_err = 0;
  int           lat1, lat2, lat4;
  logic [255:0] dig1, dig2, dig4;
  vec_t         vecs [2];

  hm_sha256_core #(.UNROLL(1), .HOLD_DIGEST(1)) u_dut1 (
    .clk(clk), .n_rst(n_rst), .start(start), .init(init), .abort(abort), .block(block),
    .ready(ready1), .busy(busy1), .done(done1), .digest(digest1));

  hm_sha256_core #(.UNROLL(2), .HOLD_DIGEST(0)) u_dut2 (
    .clk(clk), .n_rst(n_rst), .start(start), .init(init), .abort(abort), .block(block),
    .ready(ready2), .busy(busy2), .done(done2), .digest(digest2));

  hm_sha256_core #(.UNROLL(4), .HOLD_DIGEST(1)) u_dut4 (
    .clk(clk), .n_rst(n_rst), .start(start), .init(init), .abort(abort), .block(block),
    .ready(ready4), .busy(busy4), .done(done4), .digest(digest4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Accept one block on all three cores and record each one's done latency
  // (edges after the accepting edge) and the digest shown while done is high.
  task automatic run_block(input logic [511:0] blk, input logic ini);
    @(negedge clk);
    block = blk; init = ini; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; block = ~blk; init = ~ini;
    lat1 = 0; lat2 = 0; lat4 = 0;
    dig1 = '0; dig2 = '0; dig4 = '0;
    for (int n = 1; n <= 80; n++) begin
      @(posedge clk); #1;
      if (done1 && lat1 == 0) begin lat1 = n; dig1 = digest1; end
      if (done2 && lat2 == 0) begin lat2 = n; dig2 = digest2; end
      if (done4 && lat4 == 0) begin lat4 = n; dig4 = digest4; end
      if (lat1 != 0) break;
    end
  endtask

  initial begin
    int seen;
    vecs[0] = '{name: "abc",   blk: BLK_ABC,   ini: 1'b1, exp: DIG_ABC};
    vecs[1] = '{name: "empty", blk: BLK_EMPTY, ini: 1'b1, exp: DIG_EMPTY};

    n_rst = 1'b0; start = 1'b0; init = 1'b0; abort = 1'b0; block = '0;
    #2;
    check("reset U1 ready/busy/done", 256'({ready1, busy1, done1}), 256'(3'b100));
    check("reset U2 ready/busy/done", 256'({ready2, busy2, done2}), 256'(3'b100));
    check("reset U4 ready/busy/done", 256'({ready4, busy4, done4}), 256'(3'b100));
    check("reset U1 digest", digest1, '0);
    @(negedge clk);
    n_rst = 1'b1;

    for (int v = 0; v < 2; v++) begin
      run_block(vecs[v].blk, vecs[v].ini);
      check($sformatf("%s U1 digest", vecs[v].name), dig1, vecs[v].exp);
      check($sformatf("%s U2 digest", vecs[v].name), dig2, vecs[v].exp);
      check($sformatf("%s U4 digest", vecs[v].name), dig4, vecs[v].exp);
      check($sformatf("%s U1 latency", vecs[v].name), 256'(lat1), 256'(65));
      check($sformatf("%s U2 latency", vecs[v].name), 256'(lat2), 256'(33));
      check($sformatf("%s U4 latency", vecs[v].name), 256'(lat4), 256'(17));
      @(posedge clk); #1;
      check($sformatf("%s U1 done one cycle", vecs[v].name), 256'(done1), 256'(0));
      check($sformatf("%s U2 digest zero after done", vecs[v].name), digest2, '0);
      check($sformatf("%s U1 digest held", vecs[v].name), digest1, vecs[v].exp);
    end

    // Abort at round 20 of the UNROLL=1 core: no done, digest untouched.
    @(negedge clk);
    block = BLK_ABC; init = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort U1 ready/busy", 256'({ready1, busy1}), 256'(2'b10));
    seen = 0;
    for (int n = 0; n < 70; n++) begin
      @(posedge clk); #1;
      if (done1) seen++;
    end
    check("abort U1 done pulses", 256'(seen), 256'(0));
    check("abort U1 digest unchanged", digest1, DIG_EMPTY);

    run_block(BLK_ABC, 1'b1);
    check("abc after abort U1 digest", dig1, DIG_ABC);
    check("abc after abort U1 latency", 256'(lat1), 256'(65));
    check("abc after abort U2 digest", dig2, DIG_ABC);

    // Two-block message, second start issued in the done cycle of the first.
    @(posedge clk); #1;
    @(negedge clk);
    block = BLK_2A; init = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat1 = 0;
    for (int n = 1; n <= 80; n++) begin
      @(posedge clk); #1;
      if (done1) begin lat1 = n; break; end
    end
    check("2blk first latency", 256'(lat1), 256'(65));
    check("2blk ready in done cycle", 256'(ready1), 256'(1));
    block = BLK_2B; init = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; block = BLK_ABC; init = 1'b1;
    check("2blk second accepted", 256'(busy1), 256'(1));
    lat1 = 0; dig1 = '0;
    for (int n = 1; n <= 80; n++) begin
      @(posedge clk); #1;
      if (done1) begin lat1 = n; dig1 = digest1; break; end
    end
    check("2blk second latency", 256'(lat1), 256'(65));
    check("2blk digest", dig1, DIG_2BLK);

    // start pulsed while busy is ignored; reset dropped at round 40.
    @(posedge clk); #1;
    @(negedge clk);
    block = BLK_ABC; init = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat4 = 0; dig4 = '0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (n == 10) begin start = 1'b1; block = BLK_EMPTY; init = 1'b1; end
      if (n == 11) start = 1'b0;
      if (done4) begin lat4 = n; dig4 = digest4; end
    end
    check("ignored start U4 single done", 256'(lat4), 256'(17));
    check("ignored start U4 digest", dig4, DIG_ABC);
    check("ignored start U4 stays idle", 256'({ready4, busy4}), 256'(2'b10));
    check("round 40 U1 busy", 256'({ready1, busy1}), 256'(2'b01));
    n_rst = 1'b0;
    #1;
    check("mid-block reset U1 flags", 256'({ready1, busy1, done1}), 256'(3'b100));
    check("mid-block reset U1 digest", digest1, '0);
    @(posedge clk); #1;
    @(negedge clk);
    n_rst = 1'b1; block = BLK_ABC; init = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("first edge after reset accepts", 256'(busy1), 256'(1));
    lat1 = 0; dig1 = '0;
    for (int n = 1; n <= 80; n++) begin
      @(posedge clk); #1;
      if (done1) begin lat1 = n; dig1 = digest1; break; end
    end
    check("post-reset abc latency", 256'(lat1), 256'(65));
    check("post-reset abc digest", dig1, DIG_ABC);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
